sc_metadata_arbiter: RTL and testbench

//   Shares the single read port of the note metadata table among the NUM_LANES note-matcher lanes.

---
 rtl/sc_metadata_arbiter_pkg.sv | 11 +
 rtl/sc_rr_pick.sv | 38 +++
 rtl/sc_metadata_arbiter.sv | 116 +++++++++++
 tb/tb_sc_metadata_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_metadata_arbiter_pkg.sv
// Shared constants for the note-metadata arbiter and the note matcher lanes.
// Default lane count, lane index width, metadata width and table timing.
package sc_metadata_arbiter_pkg;

  localparam int SC_NUM_LANES = 37;
  localparam int SC_LANE_W    = 6;
  localparam int SC_META_W    = 16;
  localparam int SC_RAM_LAT   = 2;
  localparam int SC_CNT_W     = 8;

endpackage

// File: rtl/sc_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or after last_grant+1,
// wrapping modulo NUM_LANES (not a power of two, so no index past NUM_LANES-1 is ever produced).
module sc_rr_pick
  import sc_metadata_arbiter_pkg::*;
#(
  parameter int NUM_LANES = SC_NUM_LANES,
  parameter int LANE_W    = SC_LANE_W
) (
  input  logic [NUM_LANES-1:0] pending,
  input  logic [LANE_W-1:0]    last_grant,
  output logic                 found,
  output logic [LANE_W-1:0]    grant,
  output logic [NUM_LANES-1:0] grant_oh
);

  int start;
  int idx;

  always_comb begin
    found    = 1'b0;
    grant    = '0;
    grant_oh = '0;
    start    = int'(last_grant) + 1;
    idx      = 0;
    if (start >= NUM_LANES) start = 0;
    // Walk the rotated view; the first hit is the un-rotated grant index.
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = start + i;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = LANE_W'(idx);
      end
    end
    if (found) grant_oh = NUM_LANES'(1) << grant;
  end

endmodule

// File: rtl/sc_metadata_arbiter.sv
// Round-robin sharing of the metadata table read port among the note-matcher lanes;
// read data comes back tagged with its lane after the table latency.
module sc_metadata_arbiter
  import sc_metadata_arbiter_pkg::*;
#(
  parameter int NUM_LANES = SC_NUM_LANES,
  parameter int DATA_W    = SC_META_W,
  parameter int LANE_W    = SC_LANE_W,
  parameter int RAM_LAT   = SC_RAM_LAT,
  parameter int CNT_W     = SC_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pause,
  input  logic [NUM_LANES-1:0] req,
  output logic                 ram_rd_en,
  output logic [LANE_W-1:0]    ram_rd_addr,
  input  logic [DATA_W-1:0]    ram_rd_data,
  output logic                 rsp_valid,
  output logic [LANE_W-1:0]    rsp_lane,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [NUM_LANES-1:0] rsp_ack,
  output logic                 busy,
  output logic [CNT_W-1:0]     coalesced
);

  localparam int SUM_W = CNT_W + LANE_W + 1;

  logic [NUM_LANES-1:0] pending;
  logic [LANE_W-1:0]    last_grant;
  logic                 found;
  logic [LANE_W-1:0]    pick;
  logic [NUM_LANES-1:0] pick_oh;
  logic                 grant_vld;
  logic [NUM_LANES-1:0] grant_oh;
  logic [NUM_LANES-1:0] merge;
  logic                 inflight;
  logic                 vld_p  [1:RAM_LAT];
  logic [LANE_W-1:0]    lane_p [1:RAM_LAT];
  logic [DATA_W-1:0]    data_hold;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0]     cnt,
                                               input logic [NUM_LANES-1:0] hits);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt);
    for (int i = 0; i < NUM_LANES; i++) sum = sum + SUM_W'(hits[i]);
    if (sum > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  sc_rr_pick #(
    .NUM_LANES(NUM_LANES),
    .LANE_W   (LANE_W)
  ) u_pick (
    .pending   (pending),
    .last_grant(last_grant),
    .found     (found),
    .grant     (pick),
    .grant_oh  (pick_oh)
  );

  assign grant_vld = found & ~pause;
  assign grant_oh  = grant_vld ? pick_oh : '0;
  // A pulse on the lane granted this cycle is a fresh request, not a merge.
  assign merge     = req & pending & ~grant_oh;

  always_comb begin
    inflight = 1'b0;
    for (int k = 1; k <= RAM_LAT; k++) inflight = inflight | vld_p[k];
  end

  // Stage p0: pending/grant bookkeeping and the table read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      last_grant  <= LANE_W'(NUM_LANES - 1);
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      coalesced   <= '0;
    end else begin
      pending   <= (pending & ~grant_oh) | req;
      coalesced <= sat_add(coalesced, merge);
      ram_rd_en <= grant_vld;
      if (grant_vld) begin
        ram_rd_addr <= pick;
        last_grant  <= pick;
      end
    end
  end

  // Stages p1..pRAM_LAT: lane tags ride alongside the table read; lanes hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= RAM_LAT; k++) begin
        vld_p[k]  <= 1'b0;
        lane_p[k] <= '0;
      end
      data_hold <= '0;
    end else begin
      vld_p[1] <= ram_rd_en;
      if (ram_rd_en) lane_p[1] <= ram_rd_addr;
      for (int k = 2; k <= RAM_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        if (vld_p[k-1]) lane_p[k] <= lane_p[k-1];
      end
      if (vld_p[RAM_LAT]) data_hold <= ram_rd_data;
    end
  end

  assign rsp_valid = vld_p[RAM_LAT];
  assign rsp_lane  = lane_p[RAM_LAT];
  assign rsp_data  = rsp_valid ? ram_rd_data : data_hold;
  assign rsp_ack   = rsp_valid ? (NUM_LANES'(1) << rsp_lane) : '0;
  assign busy      = (|pending) | ram_rd_en | inflight;

endmodule

// File: tb/tb_sc_metadata_arbiter.sv
// Scoreboard bench for sc_metadata_arbiter with a 2-cycle metadata table model.
// Expected grant order is queued as stimulus is driven; reads and responses are popped and compared.
module tb_sc_metadata_arbiter;

  localparam int NL = 37;
  localparam int DW = 16;
  localparam int LW = 6;
  localparam int RL = 2;
  localparam int CW = 8;

  typedef struct {
    int lane;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pause = 1'b0;
  logic [NL-1:0] req = '0;
  logic          ram_rd_en;
  logic [LW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          rsp_valid;
  logic [LW-1:0] rsp_lane;
  logic [DW-1:0] rsp_data;
  logic [NL-1:0] rsp_ack;
  logic          busy;
  logic [CW-1:0] coalesced;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   gq[$];
  ev_t  rq[$];
  int   mon_lane;
  ev_t  mon_ev;
  logic [LW-1:0] a1 = '0;
  logic [LW-1:0] a2 = '0;

  sc_metadata_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pause      (pause),
    .req        (req),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .rsp_valid  (rsp_valid),
    .rsp_lane   (rsp_lane),
    .rsp_data   (rsp_data),
    .rsp_ack    (rsp_ack),
    .busy       (busy),
    .coalesced  (coalesced)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] tbl(input int lane);
    logic [31:0] w;
    w = 32'hA5C3 ^ (lane * 32'h1357);
    return w[DW-1:0];
  endfunction

  // Metadata table: address captured each edge, word appears two edges after the strobe.
  always @(posedge clk) begin
    a1 <= ram_rd_addr;
    a2 <= a1;
  end
  assign ram_rd_data = tbl(int'(a2));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_rd_en) begin
        if (gq.size() == 0) check_val("rd_unexpected", 64'(ram_rd_addr), 64'hFFFF);
        else begin
          mon_lane = gq.pop_front();
          check_val("rd_addr", 64'(ram_rd_addr), 64'(mon_lane));
          rq.push_back('{mon_lane, cyc + RL});
        end
      end
      if (rsp_valid) begin
        if (rq.size() == 0) check_val("rsp_unexpected", 64'(rsp_lane), 64'hFFFF);
        else begin
          mon_ev = rq.pop_front();
          check_val("rsp_lane", 64'(rsp_lane), 64'(mon_ev.lane));
          check_val("rsp_data", 64'(rsp_data), 64'(tbl(mon_ev.lane)));
          check_val("rsp_ack", 64'(rsp_ack), 64'(1) << mon_ev.lane);
          check_val("rsp_latency", 64'(cyc), 64'(mon_ev.cyc));
        end
      end
    end
  end

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((gq.size() != 0 || rq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 64'(n < budget), 64'(1));
    @(negedge clk);
    check_val({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rd_en"}, 64'(ram_rd_en), 64'(0));
    check_val({tag, "_addr"}, 64'(ram_rd_addr), 64'(0));
    check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check_val({tag, "_rsp_lane"}, 64'(rsp_lane), 64'(0));
    check_val({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    check_val({tag, "_rsp_ack"}, 64'(rsp_ack), 64'(0));
    check_val({tag, "_busy"}, 64'(busy), 64'(0));
    check_val({tag, "_coalesced"}, 64'(coalesced), 64'(0));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single request on lane 5
    gq.push_back(5);
    req = NL'(1) << 5;
    @(negedge clk);
    req = '0;
    check_val("t1_rd_early", 64'(ram_rd_en), 64'(0));
    @(negedge clk);
    check_val("t1_rd_en", 64'(ram_rd_en), 64'(1));
    check_val("t1_addr", 64'(ram_rd_addr), 64'(5));
    @(negedge clk);
    check_val("t1_rsp_early", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    check_val("t1_rsp_valid", 64'(rsp_valid), 64'(1));
    check_val("t1_rsp_ack5", 64'(rsp_ack[5]), 64'(1));
    drain("t1_drain", 20);

    // Fresh reset so lane 0 leads the all-lanes burst
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NL; i++) gq.push_back(i);
    req = '1;
    @(negedge clk);
    req = '0;
    n = 0;
    while (!ram_rd_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("t2_start", 64'(n < 10), 64'(1));
    for (int i = 0; i < NL; i++) begin
      check_val("t2_burst", 64'(ram_rd_en), 64'(1));
      @(negedge clk);
    end
    check_val("t2_burst_end", 64'(ram_rd_en), 64'(0));
    @(negedge clk);
    check_val("t2_busy_last_rsp", 64'(busy), 64'(1));
    check_val("t2_last_rsp", 64'(rsp_valid), 64'(1));
    @(negedge clk);
    check_val("t2_busy_fall", 64'(busy), 64'(0));
    drain("t2_drain", 10);

    // Wrap fairness from last_grant = 35
    gq.push_back(35);
    req = NL'(1) << 35;
    @(negedge clk);
    req = '0;
    drain("t3_setup", 20);
    pause = 1'b1;
    gq.push_back(36);
    gq.push_back(0);
    gq.push_back(3);
    req = (NL'(1) << 36) | (NL'(1) << 0) | (NL'(1) << 3);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    check_val("t3_paused", 64'(ram_rd_en), 64'(0));
    pause = 1'b0;
    drain("t3_drain", 20);

    // Pause with two reads in flight and four lanes pending
    for (int i = 10; i < 16; i++) gq.push_back(i);
    req = NL'(6'h3F) << 10;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    pause = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("t4_no_grant", 64'(ram_rd_en), 64'(0));
    end
    check_val("t4_inflight_done", 64'(rq.size()), 64'(0));
    check_val("t4_still_pending", 64'(gq.size()), 64'(4));
    check_val("t4_busy", 64'(busy), 64'(1));
    pause = 1'b0;
    drain("t4_drain", 20);

    // Coalescing on lane 7 while paused
    pause = 1'b1;
    gq.push_back(7);
    for (int k = 0; k < 3; k++) begin
      req = NL'(1) << 7;
      @(negedge clk);
      req = '0;
      @(negedge clk);
    end
    check_val("t5_coalesced", 64'(coalesced), 64'(2));
    pause = 1'b0;
    drain("t5_drain", 20);
    check_val("t5_one_read", 64'(coalesced), 64'(2));

    // Saturation: every lane requests for nine paused cycles
    pause = 1'b1;
    req = '1;
    @(negedge clk);
    check_val("t5_first_fill", 64'(coalesced), 64'(2));
    @(negedge clk);
    check_val("t5_multi", 64'(coalesced), 64'(39));
    repeat (6) @(negedge clk);
    check_val("t5_sat", 64'(coalesced), 64'(255));
    @(negedge clk);
    check_val("t5_sat_hold", 64'(coalesced), 64'(255));
    req = '0;
    for (int i = 8; i < NL; i++) gq.push_back(i);
    for (int i = 0; i < 8; i++) gq.push_back(i);
    pause = 1'b0;
    drain("t5_sat_drain", 100);

    // Reset with two reads in flight
    req = (NL'(1) << 20) | (NL'(1) << 21);
    gq.push_back(20);
    gq.push_back(21);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("t6_inflight", 64'(ram_rd_en), 64'(1));
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    gq.delete();
    rq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("t6_no_rsp", 64'(rsp_valid), 64'(0));
    end
    gq.push_back(2);
    gq.push_back(30);
    req = (NL'(1) << 30) | (NL'(1) << 2);
    @(negedge clk);
    req = '0;
    drain("t6_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
